// File: rtl/ahb_lite_sram_slave.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_lite_sram_slave
//  Purpose  : AHB-Lite responder in front of a word-organised on-chip SRAM.
//             Supports byte, halfword and word reads and writes with a
//             configurable number of wait states. Illegal accesses get a
//             two-cycle ERROR response.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    HCLK_i      in   1          bus clock, all state on rising edge
//    HRESETn_i   in   1          asynchronous active-low reset
//    HSEL_i      in   1          slave select from the system decoder
//    HADDR_i     in   ADDRWIDTH  byte address (address phase)
//    HTRANS_i    in   2          IDLE=00 BUSY=01 NONSEQ=10 SEQ=11
//    HWRITE_i    in   1          1=write, 0=read
//    HSIZE_i     in   3          000 byte, 001 halfword, 010 word
//    HBURST_i    in   3          accepted, not used for decode
//    HWDATA_i    in   DATAWIDTH  write data (data phase)
//    HREADY_i    in   1          bus-level ready from the response mux
//    HREADYOUT_o out  1          this slave's ready
//    HRESP_o     out  1          0=OKAY, 1=ERROR
//    HRDATA_o    out  DATAWIDTH  read data
// ============================================================================
module ahb_lite_sram_slave #(
  parameter int ADDRWIDTH   = 32,
  parameter int DATAWIDTH   = 32,
  parameter int MEM_DEPTH   = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                 HCLK_i,
  input  logic                 HRESETn_i,
  input  logic                 HSEL_i,
  input  logic [ADDRWIDTH-1:0] HADDR_i,
  input  logic [1:0]           HTRANS_i,
  input  logic                 HWRITE_i,
  input  logic [2:0]           HSIZE_i,
  input  logic [2:0]           HBURST_i,
  input  logic [DATAWIDTH-1:0] HWDATA_i,
  input  logic                 HREADY_i,
  output logic                 HREADYOUT_o,
  output logic                 HRESP_o,
  output logic [DATAWIDTH-1:0] HRDATA_o
);

  localparam int                 c_IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDRWIDTH:0] c_BYTE_SPAN = (ADDRWIDTH + 1)'(4 * MEM_DEPTH);
  localparam logic [3:0]         c_WAIT      = 4'(WAIT_STATES);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [3:0]             wcnt_q, wcnt_d;
  logic [c_IDX_W-1:0]     idx_q;
  logic [1:0]             lane_q;
  logic [1:0]             size_q;
  logic                   write_q;
  logic [DATAWIDTH-1:0]   mem_q [MEM_DEPTH];

  logic                   w_slave_rdy;
  logic                   w_addr_en;
  logic                   w_accept;
  logic                   w_illegal;
  state_e                 w_from_addr;
  logic [3:0]             w_be;
  logic                   w_mem_we;
  logic                   w_unused_ok;

  // HTRANS[0] only separates IDLE/BUSY and NONSEQ/SEQ, which decode alike here.
  assign w_unused_ok = ^{HTRANS_i[0], HBURST_i};

  // Only the wait/first-error cycles stall the bus.
  assign w_slave_rdy = (state_q != ST_WAIT) && (state_q != ST_ERR1);

  // Gating with our own ready keeps a pending transfer safe even if the
  // response mux misbehaves during a stall.
  assign w_addr_en = HSEL_i && HREADY_i && w_slave_rdy;
  assign w_accept  = w_addr_en && HTRANS_i[1];

  assign w_illegal = ({1'b0, HADDR_i} >= c_BYTE_SPAN)
                   || (HSIZE_i > 3'b010)
                   || ((HSIZE_i == 3'b001) && HADDR_i[0])
                   || ((HSIZE_i == 3'b010) && (HADDR_i[1:0] != 2'b00));

  // Next state chosen by a new address phase (from IDLE, DATA or ERR2).
  always_comb begin
    w_from_addr = ST_IDLE;
    if (w_accept) begin
      if (w_illegal) begin
        w_from_addr = ST_ERR1;
      end else if (c_WAIT != 4'd0) begin
        w_from_addr = ST_WAIT;
      end else begin
        w_from_addr = ST_DATA;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    HRESP_o = 1'b0;
    case (state_q)
      ST_IDLE, ST_DATA: begin
        state_d = w_from_addr;
        if (w_from_addr == ST_WAIT) wcnt_d = c_WAIT;
      end
      ST_WAIT: begin
        wcnt_d = wcnt_q - 4'd1;
        if (wcnt_q <= 4'd1) state_d = ST_DATA;
      end
      ST_ERR1: begin
        HRESP_o = 1'b1;
        state_d = ST_ERR2;
      end
      ST_ERR2: begin
        HRESP_o = 1'b1;
        state_d = w_from_addr;
        if (w_from_addr == ST_WAIT) wcnt_d = c_WAIT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign HREADYOUT_o = w_slave_rdy;

  always_ff @(posedge HCLK_i or negedge HRESETn_i) begin
    if (!HRESETn_i) begin
      state_q <= ST_IDLE;
      wcnt_q  <= 4'd0;
      idx_q   <= '0;
      lane_q  <= 2'b00;
      size_q  <= 2'b00;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      if (w_addr_en) begin
        idx_q   <= HADDR_i[c_IDX_W+1:2];
        lane_q  <= HADDR_i[1:0];
        size_q  <= HSIZE_i[1:0];
        write_q <= HWRITE_i;
      end
    end
  end

  // Little-endian byte enables; only legal sizes ever reach ST_DATA.
  always_comb begin
    w_be = 4'b0000;
    case (size_q)
      2'b00:   w_be = 4'b0001 << lane_q;
      2'b01:   w_be = lane_q[1] ? 4'b1100 : 4'b0011;
      default: w_be = 4'b1111;
    endcase
  end

  // Write data is taken on the edge that ends the data phase; a reset
  // forces ST_IDLE, so an aborted transfer never reaches this point.
  assign w_mem_we = (state_q == ST_DATA) && write_q;

  always_ff @(posedge HCLK_i) begin
    if (w_mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) mem_q[idx_q][8*b +: 8] <= HWDATA_i[8*b +: 8];
      end
    end
  end

  // Asynchronous array read so a write committed on the previous edge is
  // visible to a back-to-back read of the same word.
  assign HRDATA_o = ((state_q == ST_DATA) && !write_q) ? mem_q[idx_q] : '0;

endmodule
`default_nettype wire

// File: tb/tb_ahb_lite_sram_slave.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ahb_lite_sram_slave
//  Purpose  : Self-checking bench for ahb_lite_sram_slave. One instance with
//             no wait states and one with three share the bus; a select bit
//             steers HSEL and the ready/response mux.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ahb_lite_sram_slave;

  localparam int c_DEPTH = 64;
  localparam logic [1:0] c_IDLE = 2'b00, c_BUSY = 2'b01, c_NS = 2'b10, c_SEQ = 2'b11;
  localparam logic [2:0] c_B = 3'b000, c_H = 3'b001, c_W = 3'b010;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hsel, hwrite, act3;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize, hburst;
  logic        ro0, ro3, rs0, rs3;
  logic [31:0] rd0, rd3;
  logic        hready, mon_rdy, mon_resp;
  logic [31:0] mon_rdata;

  always #5 clk = ~clk;

  assign hready    = act3 ? ro3 : ro0;
  assign mon_rdy   = hready;
  assign mon_resp  = act3 ? rs3 : rs0;
  assign mon_rdata = act3 ? rd3 : rd0;

  ahb_lite_sram_slave #(.ADDRWIDTH(32), .DATAWIDTH(32), .MEM_DEPTH(c_DEPTH), .WAIT_STATES(0)) u_dut0 (
    .HCLK_i(clk), .HRESETn_i(rst_n), .HSEL_i(hsel & ~act3), .HADDR_i(haddr),
    .HTRANS_i(htrans), .HWRITE_i(hwrite), .HSIZE_i(hsize), .HBURST_i(hburst),
    .HWDATA_i(hwdata), .HREADY_i(hready), .HREADYOUT_o(ro0), .HRESP_o(rs0), .HRDATA_o(rd0)
  );

  ahb_lite_sram_slave #(.ADDRWIDTH(32), .DATAWIDTH(32), .MEM_DEPTH(c_DEPTH), .WAIT_STATES(3)) u_dut3 (
    .HCLK_i(clk), .HRESETn_i(rst_n), .HSEL_i(hsel & act3), .HADDR_i(haddr),
    .HTRANS_i(htrans), .HWRITE_i(hwrite), .HSIZE_i(hsize), .HBURST_i(hburst),
    .HWDATA_i(hwdata), .HREADY_i(hready), .HREADYOUT_o(ro3), .HRESP_o(rs3), .HRDATA_o(rd3)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One isolated transfer: address phase, then data phase until ready.
  task automatic xfer(input logic sel, input logic [1:0] tr, input logic wr,
                      input logic [2:0] sz, input logic [31:0] ad, input logic [31:0] wd,
                      output int cyc, output logic rf, output logic rl,
                      output logic [31:0] rdl, output logic [31:0] rdo);
    logic done;
    @(negedge clk);
    hsel = sel; htrans = tr; hwrite = wr; hsize = sz; haddr = ad;
    @(posedge clk);
    #1;
    hsel = 1'b0; htrans = c_IDLE; hwdata = wd;
    cyc = 0; rdo = 32'h0; done = 1'b0; rf = 1'bx; rl = 1'bx; rdl = 32'hx;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      cyc++;
      if (k == 0) rf = mon_resp;
      if (mon_rdy) begin
        done = 1'b1;
        rl   = mon_resp;
        rdl  = mon_rdata;
      end else begin
        rdo = rdo | mon_rdata;
      end
    end
    if (!done) cyc = -1;
  endtask

  typedef struct {
    logic        sel;
    logic [1:0]  tr;
    logic        wr;
    logic [2:0]  sz;
    logic [31:0] ad;
    logic [31:0] wd;
    int          cyc;
    logic        resp;
    logic [31:0] rd;
  } vec_t;

  vec_t vt [23];

  initial begin
    int          cyc, total;
    logic        rf, rl, got;
    logic [31:0] rdl, rdo;

    hsel = 0; htrans = c_IDLE; hwrite = 0; hsize = c_W; haddr = 0;
    hwdata = 0; hburst = 3'b000; act3 = 0;

    //          sel tr     wr  sz   addr      wdata          cyc resp rdata
    vt[0]  = '{1, c_NS,  1, c_W, 32'h08,  32'hDEADBEEF, 1, 0, 32'h0};
    vt[1]  = '{1, c_NS,  0, c_W, 32'h08,  32'h0,        1, 0, 32'hDEADBEEF};
    vt[2]  = '{1, c_NS,  1, c_W, 32'h04,  32'h11223344, 1, 0, 32'h0};
    vt[3]  = '{1, c_NS,  1, c_B, 32'h06,  32'h00AA0000, 1, 0, 32'h0};
    vt[4]  = '{1, c_NS,  1, c_H, 32'h04,  32'h0000BEEF, 1, 0, 32'h0};
    vt[5]  = '{1, c_NS,  0, c_W, 32'h04,  32'h0,        1, 0, 32'h11AABEEF};
    vt[6]  = '{1, c_NS,  0, c_W, 32'h02,  32'h0,        2, 1, 32'h0};
    vt[7]  = '{1, c_NS,  1, c_W, 32'h100, 32'hFFFFFFFF, 2, 1, 32'h0};
    vt[8]  = '{1, c_NS,  1, c_W, 32'h09,  32'h12345678, 2, 1, 32'h0};
    vt[9]  = '{1, c_NS,  0, c_W, 32'h08,  32'h0,        1, 0, 32'hDEADBEEF};
    vt[10] = '{1, c_NS,  0, c_B, 32'h07,  32'h0,        1, 0, 32'h11AABEEF};
    vt[11] = '{1, c_NS,  0, c_H, 32'h05,  32'h0,        2, 1, 32'h0};
    vt[12] = '{1, c_NS,  0, 3'b011, 32'h00, 32'h0,      2, 1, 32'h0};
    vt[13] = '{1, c_BUSY,1, c_W, 32'h08,  32'h0,        1, 0, 32'h0};
    vt[14] = '{0, c_NS,  1, c_W, 32'h08,  32'h0,        1, 0, 32'h0};
    vt[15] = '{1, c_SEQ, 0, c_W, 32'h08,  32'h0,        1, 0, 32'hDEADBEEF};
    vt[16] = '{1, c_IDLE,1, c_W, 32'h04,  32'h0,        1, 0, 32'h0};
    vt[17] = '{1, c_NS,  0, c_H, 32'h06,  32'h0,        1, 0, 32'h11AABEEF};
    vt[18] = '{1, c_NS,  0, c_W, 32'h04,  32'h0,        1, 0, 32'h11AABEEF};
    vt[19] = '{1, c_NS,  1, c_W, 32'hFC,  32'hA5A5A5A5, 1, 0, 32'h0};
    vt[20] = '{1, c_NS,  0, c_W, 32'hFC,  32'h0,        1, 0, 32'hA5A5A5A5};
    vt[21] = '{1, c_NS,  1, c_B, 32'hFF,  32'h3C000000, 1, 0, 32'h0};
    vt[22] = '{1, c_NS,  0, c_W, 32'hFC,  32'h0,        1, 0, 32'h3CA5A5A5};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst ready0", {31'h0, ro0}, 32'h1);
    chk("rst resp0",  {31'h0, rs0}, 32'h0);
    chk("rst rdata0", rd0, 32'h0);
    chk("rst ready3", {31'h0, ro3}, 32'h1);
    rst_n = 1'b1;

    // Table-driven single transfers, zero wait states
    for (int i = 0; i < 23; i++) begin
      xfer(vt[i].sel, vt[i].tr, vt[i].wr, vt[i].sz, vt[i].ad, vt[i].wd, cyc, rf, rl, rdl, rdo);
      chk($sformatf("v%0d cycles", i), cyc, vt[i].cyc);
      chk($sformatf("v%0d resp first", i), {31'h0, rf}, {31'h0, vt[i].resp});
      chk($sformatf("v%0d resp last", i), {31'h0, rl}, {31'h0, vt[i].resp});
      chk($sformatf("v%0d rdata", i), rdl, vt[i].rd);
      chk($sformatf("v%0d rdata early", i), rdo, 32'h0);
    end

    // Back-to-back write then read of the same word
    @(negedge clk);
    hsel = 1; htrans = c_NS; hwrite = 1; hsize = c_W; haddr = 32'h10;
    @(posedge clk); #1;
    hwrite = 0; hwdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("b2b wr ready", {31'h0, mon_rdy}, 32'h1);
    chk("b2b wr resp", {31'h0, mon_resp}, 32'h0);
    @(posedge clk); #1;
    hsel = 0; htrans = c_IDLE;
    @(negedge clk);
    chk("b2b rd ready", {31'h0, mon_rdy}, 32'h1);
    chk("b2b rd data", mon_rdata, 32'hCAFEF00D);

    // Three wait states
    @(negedge clk);
    act3 = 1'b1;
    xfer(1, c_NS, 1, c_W, 32'h10, 32'h01020304, cyc, rf, rl, rdl, rdo);
    chk("ws3 wr cycles", cyc, 4);
    xfer(1, c_NS, 0, c_W, 32'h10, 32'h0, cyc, rf, rl, rdl, rdo);
    chk("ws3 rd cycles", cyc, 4);
    chk("ws3 rd resp", {31'h0, rl}, 32'h0);
    chk("ws3 rd data", rdl, 32'h01020304);
    chk("ws3 rd early data", rdo, 32'h0);
    for (int i = 0; i < 4; i++) begin
      xfer(1, c_NS, 1, c_W, 32'h20 + 4*i, 32'hB0000000 + i, cyc, rf, rl, rdl, rdo);
      chk($sformatf("ws3 fill%0d cycles", i), cyc, 4);
    end

    // Pipelined four-beat SEQ read burst
    @(negedge clk);
    hsel = 1; htrans = c_NS; hwrite = 0; hsize = c_W; haddr = 32'h20; hburst = 3'b011;
    total = 0;
    for (int b = 0; b < 4; b++) begin
      @(posedge clk); #1;
      if (b < 3) begin
        htrans = c_SEQ; haddr = 32'h20 + 4*(b+1);
      end else begin
        hsel = 0; htrans = c_IDLE; hburst = 3'b000;
      end
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
        @(negedge clk);
        total++;
        if (mon_rdy) begin
          got = 1'b1;
          chk($sformatf("burst beat%0d data", b), mon_rdata, 32'hB0000000 + b);
        end
      end
      chk($sformatf("burst beat%0d done", b), {31'h0, got}, 32'h1);
    end
    chk("burst total cycles", total, 16);

    // Asynchronous reset in the middle of a waited write
    @(negedge clk);
    hsel = 1; htrans = c_NS; hwrite = 1; hsize = c_W; haddr = 32'h10;
    @(posedge clk); #1;
    hsel = 0; htrans = c_IDLE; hwdata = 32'hFFFF0000;
    @(negedge clk);
    chk("mid-wait ready", {31'h0, mon_rdy}, 32'h0);
    #1 rst_n = 1'b0;
    #1;
    chk("async rst ready", {31'h0, mon_rdy}, 32'h1);
    chk("async rst resp", {31'h0, mon_resp}, 32'h0);
    chk("async rst rdata", mon_rdata, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    xfer(1, c_NS, 0, c_W, 32'h10, 32'h0, cyc, rf, rl, rdl, rdo);
    chk("post rst cycles", cyc, 4);
    chk("post rst data", rdl, 32'h01020304);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ahb_lite_sram_slave.md
Name: ahb_lite_sram_slave

Overview:
- AHB-Lite responder (slave) holding a word-organised on-chip SRAM; the completer side of the bus that the team's AHB-Lite master drives.
- Decodes transfer type, size and address; performs byte, halfword and word reads/writes with a configurable number of wait states.
- Returns a two-cycle ERROR response for illegal accesses.
- Sits behind the system decoder/mux: HSEL comes from the decoder, HREADYOUT/HRESP/HRDATA go to the response mux.

Parameters:
- ADDRWIDTH, 32, HADDR width.
- DATAWIDTH, 32, HWDATA/HRDATA width (fixed at 32 for this block).
- MEM_DEPTH, 1024, number of 32-bit words; byte span = 4*MEM_DEPTH.
- WAIT_STATES, 0, HREADYOUT-low cycles inserted per OKAY transfer (0..15).

Ports:
- HCLK  in  1  bus clock, all state on rising edge.
- HRESETn  in  1  asynchronous active-low reset.
- HSEL  in  1  slave select from decoder.
- HADDR  in  ADDRWIDTH  byte address (address phase).
- HTRANS  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- HWRITE  in  1  1=write, 0=read.
- HSIZE  in  3  000 byte, 001 halfword, 010 word.
- HBURST  in  3  accepted, not used for decode.
- HWDATA  in  DATAWIDTH  write data (data phase).
- HREADY  in  1  bus-level ready (from response mux).
- HREADYOUT  out  1  this slave's ready.
- HRESP  out  1  0=OKAY, 1=ERROR.
- HRDATA  out  DATAWIDTH  read data.

Behaviour:
- Reset (async, HRESETn=0): HREADYOUT=1, HRESP=0, HRDATA=0, FSM=ST_IDLE, latched address-phase registers cleared. Memory contents are not reset. Reset asserted mid-transfer aborts it; no write is committed.
- Address phase accept: on rising HCLK when HSEL=1 and HREADY=1, latch HADDR, HWRITE, HSIZE, HTRANS.
  - HTRANS IDLE/BUSY, or HSEL=0: no transfer; the next cycle is a zero-wait OKAY (HREADYOUT=1, HRESP=0).
- Legality check for NONSEQ/SEQ: error if any of the following holds:
  - HADDR >= 4*MEM_DEPTH;
  - HSIZE > 010;
  - halfword with HADDR[0]=1;
  - word with HADDR[1:0]!=00.
- FSM states:
  - ST_IDLE: waiting for an accepted address phase.
    - Legal transfer with WAIT_STATES>0: go to ST_WAIT, load counter=WAIT_STATES.
    - Legal transfer with WAIT_STATES=0: go to ST_DATA.
    - Illegal transfer: go to ST_ERR1.
  - ST_WAIT: HREADYOUT=0, HRESP=0; counter decrements each cycle; go to ST_DATA when counter reaches 1.
  - ST_DATA: HREADYOUT=1, HRESP=0; transfer completes this cycle. If a new address phase is accepted in this same cycle, the next state is decided as from ST_IDLE (back-to-back pipelining); otherwise ST_IDLE.
  - ST_ERR1: HREADYOUT=0, HRESP=1; next state ST_ERR2.
  - ST_ERR2: HREADYOUT=1, HRESP=1; a new address phase may be accepted; next state is decided as from ST_IDLE.
- Latency: an OKAY transfer takes WAIT_STATES+1 data-phase cycles; ERROR always takes 2.
- Write:
  - HWDATA is sampled on the edge ending ST_DATA.
  - Only the addressed byte lanes are written (little-endian): byte lane = addr[1:0]; halfword lanes = addr[1]*2 and +1.
  - Other bytes are unchanged. Errored writes modify nothing.
- Read:
  - HRDATA presents the full addressed word (all lanes) only during ST_DATA of a read; 0 in all other cycles, including error cycles.
  - A read whose data phase follows a write to the same word returns the new data (the write commits on the edge before the read's data phase).
- Address phase during wait states: HREADY=0, so it is not accepted; the master must hold it stable.

Test Plan:
- Reset: HRESETn=0 asynchronously mid-ST_WAIT -> HREADYOUT=1, HRESP=0, HRDATA=0 immediately. Pending write to 0x10 not committed; later read of 0x10 returns its prior value.
- Word write/read, WAIT_STATES=0: NONSEQ write 0x0000_0008, data 0xDEADBEEF, then NONSEQ read 0x8 back-to-back -> both data phases complete in 1 cycle, OKAY; read returns 0xDEADBEEF.
- Byte lanes: word 0x4 = 0x11223344; byte write 0xAA to addr 0x6; halfword write 0xBEEF to addr 0x4 -> word read of 0x4 returns 0x11AABEEF.
- Wait states, WAIT_STATES=3: single read -> HREADYOUT low for exactly 3 cycles, high on the 4th with data. SEQ burst of 4 words -> 16 data-phase cycles total.
- Error: word read at 0x2 (misaligned), then write to 4*MEM_DEPTH (out of range) -> each gives HREADYOUT 0 then 1 with HRESP=1 on both cycles, HRDATA=0; memory unchanged. Following NONSEQ is OKAY.
- IDLE/BUSY and deselect: HTRANS=BUSY with HSEL=1, then NONSEQ with HSEL=0 -> HREADYOUT stays 1, HRESP 0, no memory access.
